// File: rtl/obstacle_scheduler.sv
// Purpose: game-logic controller for On-The-Run; owns NUM_SLOTS falling obstacles (spawn, advance, score, collide).
// Latency: frame_tick to updated slot outputs is NUM_SLOTS+2 cycles; outputs hold steady while waiting for the next frame.
// Backpressure: none; frame_tick is dropped unless waiting, start is honoured only when idle or game over.
// Ports: clk/rst_n (async active-low), start, frame_tick, player_lane in; obj_active/obj_lane/obj_y per slot,
//        pattern (last spawn sprite), hit (one-cycle collision pulse), game_over (level), score (saturating) out.
// Build option: define INVINCIBLE_EN to keep playing after a collision (hit still pulses, game_over never rises).
module obstacle_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int Y_MAX      = 479,
    parameter int PLAYER_Y   = 400,
    parameter int PLAYER_H   = 48,
    parameter int OBJ_H      = 40,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 8,
    parameter int GAP_INIT   = 32,
    parameter int GAP_MIN    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic [1:0]             player_lane,
    output logic [NUM_SLOTS-1:0]   obj_active,
    output logic [2*NUM_SLOTS-1:0] obj_lane,
    output logic [10*NUM_SLOTS-1:0] obj_y,
    output logic [1:0]             pattern,
    output logic                   hit,
    output logic                   game_over,
    output logic [15:0]            score
);

    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_UPDATE, S_SPAWN, S_CHECK, S_OVER} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [NUM_SLOTS-1:0]       act_q, act_d;
    logic [NUM_SLOTS-1:0][1:0]  lane_q, lane_d;
    logic [NUM_SLOTS-1:0][9:0]  y_q, y_d;
    logic [1:0]                 pat_q, pat_d;
    logic [15:0]                score_q, score_d;
    logic [7:0]                 speed_q, speed_d;
    logic [7:0]                 gap_q, gap_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       bump_q, bump_d;   // a multiple of 16 was crossed this frame
    logic [15:0]                lfsr_q, lfsr_d;

    logic [10:0]                y_next;
    logic                       spawned;
    logic                       coll;

    assign obj_active = act_q;
    assign obj_lane   = lane_q;
    assign obj_y      = y_q;
    assign pattern    = pat_q;
    assign score      = score_q;
    assign game_over  = (state_q == S_OVER);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        lane_d  = lane_q;
        y_d     = y_q;
        pat_d   = pat_q;
        score_d = score_q;
        speed_d = speed_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        bump_d  = bump_q;
        hit     = 1'b0;
        y_next  = 11'd0;
        spawned = 1'b0;
        coll    = 1'b0;
        // x^16+x^14+x^13+x^11+1, right-shifting form; free-runs in every state
        lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        case (state_q)
            S_IDLE, S_OVER: begin
                // start has priority; a coincident frame_tick is simply not looked at here
                if (start) begin
                    act_d   = '0;
                    lane_d  = '0;
                    y_d     = '0;
                    score_d = '0;
                    speed_d = 8'(SPEED_INIT);
                    gap_d   = 8'(GAP_INIT);
                    cnt_d   = 8'(GAP_INIT);
                    bump_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (frame_tick) begin
                    idx_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // 11-bit sum so a slot near the bottom cannot wrap back to the top
                y_next = {1'b0, y_q[idx_q]} + 11'(speed_q);
                if (act_q[idx_q]) begin
                    if (y_next > 11'(Y_MAX)) begin
                        act_d[idx_q] = 1'b0;
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                            if (score_d[3:0] == 4'd0) bump_d = 1'b1;
                        end
                    end else begin
                        y_d[idx_q] = y_next[9:0];
                    end
                end
                if (idx_q == IW'(NUM_SLOTS - 1)) state_d = S_SPAWN;
                else                             idx_d   = idx_q + 1'b1;
            end
            S_SPAWN: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_d == 8'd0) begin
                    cnt_d = gap_q;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (!spawned && !act_q[i]) begin
                            spawned   = 1'b1;
                            act_d[i]  = 1'b1;
                            y_d[i]    = 10'd0;
                            lane_d[i] = lfsr_q[1:0];
                            pat_d     = lfsr_q[3:2];
                        end
                    end
                end
                state_d = S_CHECK;
            end
            S_CHECK: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (act_q[i] && (lane_q[i] == player_lane) &&
                        ({1'b0, y_q[i]} + 11'(OBJ_H) > 11'(PLAYER_Y)) &&
                        ({1'b0, y_q[i]} < 11'(PLAYER_Y + PLAYER_H)))
                        coll = 1'b1;
                end
                hit = coll;
                // difficulty step lands here so the whole frame ran at one speed/gap
                if (bump_q) begin
                    speed_d = (speed_q >= 8'(SPEED_MAX)) ? 8'(SPEED_MAX) : speed_q + 8'd1;
                    gap_d   = (gap_q >= 8'(GAP_MIN + 2)) ? gap_q - 8'd2 : 8'(GAP_MIN);
                    bump_d  = 1'b0;
                end
`ifdef INVINCIBLE_EN
                state_d = S_WAIT;
`else
                state_d = coll ? S_OVER : S_WAIT;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            act_q   <= '0;
            lane_q  <= '0;
            y_q     <= '0;
            pat_q   <= '0;
            score_q <= '0;
            speed_q <= 8'(SPEED_INIT);
            gap_q   <= 8'(GAP_INIT);
            cnt_q   <= 8'(GAP_INIT);
            bump_q  <= 1'b0;
            lfsr_q  <= 16'hACE1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            lane_q  <= lane_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            score_q <= score_d;
            speed_q <= speed_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            bump_q  <= bump_d;
            lfsr_q  <= lfsr_d;
        end
    end

endmodule
